// File: rtl/dws_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dws_sched_pkg
//  Purpose  : Shared types and helpers for the depthwise-separable layer
//             tile scheduler: FSM state encoding, the 3x3 kernel / pad-1
//             geometry constants and the input-window extent function.
//  Revision : 1.0 - initial release
// ============================================================================
package dws_sched_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CHECK   = 3'd1,
        S_SETUP   = 3'd2,
        S_ISSUE   = 3'd3,
        S_WAIT    = 3'd4,
        S_ADVANCE = 3'd5,
        S_DONE    = 3'd6
    } state_e;

    localparam int PAD    = 1;
    localparam int KERNEL = 3;

    // Input rows/cols needed to produce out_ext outputs:
    // (out_ext-1)*stride + KERNEL. Stride is only ever 1 or 2, so stride 2 is
    // a shift. Result is wide enough that no legal 32-bit operand overflows.
    function automatic logic [33:0] in_extent(input logic [31:0] out_ext,
                                              input logic        stride2);
        logic [33:0] span;
        span = {2'b00, out_ext} - 34'd1;
        if (stride2) begin
            span = span << 1;
        end
        return span + 34'(KERNEL);
    endfunction

endpackage
`default_nettype wire

// File: rtl/dws_tile_geom.sv
`default_nettype none
// ============================================================================
//  Module   : dws_tile_geom
//  Purpose  : Combinational tile geometry calculator. From the output cursor
//             (row, col) and layer configuration it produces the edge-clipped
//             output extent and the padded input window of one tile.
//  Ports    : row_i/col_i         output tile origin
//             img_h_i/img_w_i     output map size
//             tile_h_i/tile_w_i   nominal output tile size
//             stride2_i           1 = stride 2, 0 = stride 1
//             in_*_o / out_*_o    the six tile fields (origins pass through)
//  Revision : 1.0 - initial release
// ============================================================================
module dws_tile_geom
    import dws_sched_pkg::*;
#(
    parameter int DIM_W = 16
) (
    input  logic [DIM_W-1:0]        row_i,
    input  logic [DIM_W-1:0]        col_i,
    input  logic [DIM_W-1:0]        img_h_i,
    input  logic [DIM_W-1:0]        img_w_i,
    input  logic [DIM_W-1:0]        tile_h_i,
    input  logic [DIM_W-1:0]        tile_w_i,
    input  logic                    stride2_i,
    output logic signed [DIM_W:0]   in_row_o,
    output logic signed [DIM_W:0]   in_col_o,
    output logic [DIM_W-1:0]        in_h_o,
    output logic [DIM_W-1:0]        in_w_o,
    output logic [DIM_W-1:0]        out_row_o,
    output logic [DIM_W-1:0]        out_col_o,
    output logic [DIM_W-1:0]        out_h_o,
    output logic [DIM_W-1:0]        out_w_o
);

    logic [DIM_W-1:0] rem_h;
    logic [DIM_W-1:0] rem_w;
    logic [DIM_W:0]   row_scaled;
    logic [DIM_W:0]   col_scaled;

    // Cursor is always inside the map, so the remainder never underflows.
    assign rem_h   = img_h_i - row_i;
    assign rem_w   = img_w_i - col_i;
    assign out_h_o = (tile_h_i < rem_h) ? tile_h_i : rem_h;
    assign out_w_o = (tile_w_i < rem_w) ? tile_w_i : rem_w;

    assign out_row_o = row_i;
    assign out_col_o = col_i;

    // Origin scaled by stride (shift for stride 2), then back off by the pad.
    assign row_scaled = stride2_i ? {row_i, 1'b0} : {1'b0, row_i};
    assign col_scaled = stride2_i ? {col_i, 1'b0} : {1'b0, col_i};
    assign in_row_o   = $signed(row_scaled - (DIM_W+1)'(PAD));
    assign in_col_o   = $signed(col_scaled - (DIM_W+1)'(PAD));

    assign in_h_o = DIM_W'(in_extent(32'(out_h_o), stride2_i));
    assign in_w_o = DIM_W'(in_extent(32'(out_w_o), stride2_i));

endmodule
`default_nettype wire

// File: rtl/dws_layer_tile_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : dws_layer_tile_scheduler
//  Purpose  : Walks one depthwise-separable layer's output map in row-major
//             tiles, handing each tile's geometry to the tile runner and
//             waiting for it to finish.
//  Ports    : start/abort         layer control from the layer controller
//             busy/done/error     layer status (done/error are 1-cycle pulses)
//             cfg_*               layer geometry, latched at start
//             runner_start/done   per-tile handshake with the tile runner
//             tile_*              registered per-tile fields for the runner
//             tile_count          tiles completed in the current layer
//  Revision : 1.0 - initial release
// ============================================================================
module dws_layer_tile_scheduler
    import dws_sched_pkg::*;
#(
    parameter int DIM_W         = 16,
    parameter int MAX_TILE_IN_H = 33,
    parameter int MAX_TILE_IN_W = 33,
    parameter int CNT_W         = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    abort,
    output logic                    busy,
    output logic                    done,
    output logic                    error,
    input  logic [DIM_W-1:0]        cfg_out_img_h,
    input  logic [DIM_W-1:0]        cfg_out_img_w,
    input  logic [DIM_W-1:0]        cfg_tile_h,
    input  logic [DIM_W-1:0]        cfg_tile_w,
    input  logic [DIM_W-1:0]        cfg_stride,
    output logic                    runner_start,
    input  logic                    runner_done,
    output logic signed [DIM_W:0]   tile_in_row,
    output logic signed [DIM_W:0]   tile_in_col,
    output logic [DIM_W-1:0]        tile_in_h,
    output logic [DIM_W-1:0]        tile_in_w,
    output logic [DIM_W-1:0]        tile_out_row,
    output logic [DIM_W-1:0]        tile_out_col,
    output logic [DIM_W-1:0]        tile_out_h,
    output logic [DIM_W-1:0]        tile_out_w,
    output logic [CNT_W-1:0]        tile_count
);

    state_e state_q, state_d;

    logic [DIM_W-1:0] img_h_q, img_w_q, tile_h_q, tile_w_q, stride_q;
    logic [DIM_W-1:0] row_q, row_d, col_q, col_d;
    logic [CNT_W-1:0] count_q;
    logic             abort_q, err_q;

    logic             stride2;
    logic             cfg_bad;
    logic             abort_eff;
    logic [DIM_W:0]   col_sum, row_sum;
    logic             col_wrap, layer_end;

    logic signed [DIM_W:0] g_in_row, g_in_col;
    logic [DIM_W-1:0]      g_in_h, g_in_w, g_out_row, g_out_col, g_out_h, g_out_w;

    assign stride2   = (stride_q == DIM_W'(2));
    assign abort_eff = abort_q | abort;

    always_comb begin
        cfg_bad = 1'b0;
        if (img_h_q == '0 || img_w_q == '0 || tile_h_q == '0 || tile_w_q == '0) begin
            cfg_bad = 1'b1;
        end else if (stride_q != DIM_W'(1) && !stride2) begin
            cfg_bad = 1'b1;
        end else if (in_extent(32'(tile_h_q), stride2) > 34'(MAX_TILE_IN_H) ||
                     in_extent(32'(tile_w_q), stride2) > 34'(MAX_TILE_IN_W)) begin
            cfg_bad = 1'b1;
        end
    end

    // Cursor adds carry one extra bit so the wrap compare is exact even when
    // the cursor plus tile size exceeds the DIM_W range.
    assign col_sum   = {1'b0, col_q} + {1'b0, tile_w_q};
    assign row_sum   = {1'b0, row_q} + {1'b0, tile_h_q};
    assign col_wrap  = (col_sum >= {1'b0, img_w_q});
    assign layer_end = col_wrap && (row_sum >= {1'b0, img_h_q});

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        case (state_q)
            S_IDLE:    if (start) state_d = S_CHECK;
            S_CHECK:   state_d = (cfg_bad || abort_eff) ? S_DONE : S_SETUP;
            S_SETUP:   state_d = abort_eff ? S_DONE : S_ISSUE;
            S_ISSUE:   state_d = S_WAIT;
            S_WAIT:    if (runner_done) state_d = S_ADVANCE;
            S_ADVANCE: begin
                if (col_wrap) begin
                    col_d = '0;
                    row_d = row_sum[DIM_W-1:0];
                end else begin
                    col_d = col_sum[DIM_W-1:0];
                end
                state_d = (layer_end || abort_eff) ? S_DONE : S_SETUP;
            end
            S_DONE:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    dws_tile_geom #(.DIM_W(DIM_W)) u_geom (
        .row_i     (row_q),
        .col_i     (col_q),
        .img_h_i   (img_h_q),
        .img_w_i   (img_w_q),
        .tile_h_i  (tile_h_q),
        .tile_w_i  (tile_w_q),
        .stride2_i (stride2),
        .in_row_o  (g_in_row),
        .in_col_o  (g_in_col),
        .in_h_o    (g_in_h),
        .in_w_o    (g_in_w),
        .out_row_o (g_out_row),
        .out_col_o (g_out_col),
        .out_h_o   (g_out_h),
        .out_w_o   (g_out_w)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            img_h_q      <= '0;
            img_w_q      <= '0;
            tile_h_q     <= '0;
            tile_w_q     <= '0;
            stride_q     <= '0;
            row_q        <= '0;
            col_q        <= '0;
            count_q      <= '0;
            abort_q      <= 1'b0;
            err_q        <= 1'b0;
            tile_in_row  <= '0;
            tile_in_col  <= '0;
            tile_in_h    <= '0;
            tile_in_w    <= '0;
            tile_out_row <= '0;
            tile_out_col <= '0;
            tile_out_h   <= '0;
            tile_out_w   <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;

            if (state_q == S_IDLE && start) begin
                img_h_q  <= cfg_out_img_h;
                img_w_q  <= cfg_out_img_w;
                tile_h_q <= cfg_tile_h;
                tile_w_q <= cfg_tile_w;
                stride_q <= cfg_stride;
                row_q    <= '0;
                col_q    <= '0;
                count_q  <= '0;
            end

            if (state_q == S_SETUP) begin
                tile_in_row  <= g_in_row;
                tile_in_col  <= g_in_col;
                tile_in_h    <= g_in_h;
                tile_in_w    <= g_in_w;
                tile_out_row <= g_out_row;
                tile_out_col <= g_out_col;
                tile_out_h   <= g_out_h;
                tile_out_w   <= g_out_w;
            end

            if (state_q == S_WAIT && runner_done && count_q != '1) begin
                count_q <= count_q + CNT_W'(1);
            end

            // Abort and error are sticky for the layer and dropped on the way
            // back to idle so the next layer starts clean.
            if (state_d == S_IDLE) begin
                abort_q <= 1'b0;
                err_q   <= 1'b0;
            end else begin
                if (state_q != S_IDLE) abort_q <= abort_q | abort;
                if (state_q == S_CHECK) err_q <= cfg_bad;
            end
        end
    end

    assign busy         = (state_q != S_IDLE);
    assign done         = (state_q == S_DONE);
    assign error        = (state_q == S_DONE) && err_q;
    assign runner_start = (state_q == S_ISSUE);
    assign tile_count   = count_q;

endmodule
`default_nettype wire

// File: tb/tb_dws_layer_tile_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dws_layer_tile_scheduler
//  Purpose  : Scoreboard testbench for dws_layer_tile_scheduler. A reference
//             model enumerates each layer's tiles; a monitor compares every
//             runner_start and done against the expected queues.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dws_layer_tile_scheduler;

    localparam int DIM_W = 16;
    localparam int CNT_W = 16;
    localparam int MAX_IN = 33;

    logic clk, rst, start, abort, busy, done, error, runner_start, runner_done;
    logic [DIM_W-1:0] cfg_out_img_h, cfg_out_img_w, cfg_tile_h, cfg_tile_w, cfg_stride;
    logic signed [DIM_W:0] tile_in_row, tile_in_col;
    logic [DIM_W-1:0] tile_in_h, tile_in_w, tile_out_row, tile_out_col, tile_out_h, tile_out_w;
    logic [CNT_W-1:0] tile_count;

    dws_layer_tile_scheduler #(
        .DIM_W(DIM_W), .MAX_TILE_IN_H(MAX_IN), .MAX_TILE_IN_W(MAX_IN), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .busy(busy), .done(done), .error(error),
        .cfg_out_img_h(cfg_out_img_h), .cfg_out_img_w(cfg_out_img_w),
        .cfg_tile_h(cfg_tile_h), .cfg_tile_w(cfg_tile_w), .cfg_stride(cfg_stride),
        .runner_start(runner_start), .runner_done(runner_done),
        .tile_in_row(tile_in_row), .tile_in_col(tile_in_col),
        .tile_in_h(tile_in_h), .tile_in_w(tile_in_w),
        .tile_out_row(tile_out_row), .tile_out_col(tile_out_col),
        .tile_out_h(tile_out_h), .tile_out_w(tile_out_w),
        .tile_count(tile_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int ir; int ic; int ih; int iw; int orow; int ocol; int oh; int ow; } tile_t;
    typedef struct { bit err; int cnt; } end_t;

    tile_t exp_tiles[$];
    end_t  exp_end[$];

    int n_cmp = 0, n_fail = 0;
    int start_cyc = 0, last_done_cyc = 0;
    int starts_seen = 0, layer_ends = 0;
    int resp_delay = 0;
    int gen = 0;
    bit first_tile = 1'b0;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Reference model: enumerate the row-major tiling directly from the
    // layer's rules. abort_n > 0 limits the layer to that many tiles.
    task automatic build_layer(input int h, input int w, input int th, input int tw,
                               input int s, input int abort_n);
        bit    ok;
        int    n;
        tile_t t;
        end_t  e;
        ok = (h > 0) && (w > 0) && (th > 0) && (tw > 0) && (s == 1 || s == 2)
             && ((th - 1) * s + 3 <= MAX_IN) && ((tw - 1) * s + 3 <= MAX_IN);
        n = 0;
        if (ok) begin
            for (int r = 0; r < h; r += th) begin
                for (int c = 0; c < w; c += tw) begin
                    if (abort_n == 0 || n < abort_n) begin
                        t.orow = r;  t.ocol = c;
                        t.oh   = (th < h - r) ? th : h - r;
                        t.ow   = (tw < w - c) ? tw : w - c;
                        t.ir   = r * s - 1;
                        t.ic   = c * s - 1;
                        t.ih   = (t.oh - 1) * s + 3;
                        t.iw   = (t.ow - 1) * s + 3;
                        exp_tiles.push_back(t);
                        n++;
                    end
                end
            end
        end
        e.err = !ok;
        e.cnt = n;
        exp_end.push_back(e);
    endtask

    // Monitor: compares DUT presentations against the scoreboard queues.
    initial begin : monitor
        tile_t t;
        end_t  e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (runner_start) begin
                    starts_seen++;
                    if (first_tile) check("lat_start_to_issue", cyc - start_cyc, 3);
                    else            check("lat_done_to_issue", cyc - last_done_cyc, 3);
                    first_tile = 1'b0;
                    if (exp_tiles.size() == 0) begin
                        fail_now("unexpected_runner_start");
                    end else begin
                        t = exp_tiles.pop_front();
                        check("tile_in_row",  $signed(tile_in_row), t.ir);
                        check("tile_in_col",  $signed(tile_in_col), t.ic);
                        check("tile_in_h",    tile_in_h,    t.ih);
                        check("tile_in_w",    tile_in_w,    t.iw);
                        check("tile_out_row", tile_out_row, t.orow);
                        check("tile_out_col", tile_out_col, t.ocol);
                        check("tile_out_h",   tile_out_h,   t.oh);
                        check("tile_out_w",   tile_out_w,   t.ow);
                    end
                end
                if (error && !done) fail_now("error_without_done");
                if (done) begin
                    if (exp_end.size() == 0) begin
                        fail_now("unexpected_done");
                    end else begin
                        e = exp_end.pop_front();
                        check("done_error", error, e.err);
                        check("done_tile_count", tile_count, e.cnt);
                        check("tiles_not_issued", exp_tiles.size(), 0);
                    end
                    layer_ends++;
                end
            end
        end
    end

    // Tile runner model: one runner_done pulse some cycles after each start.
    initial begin : responder
        runner_done = 1'b0;
        forever begin
            @(negedge clk);
            if (runner_start && !rst) begin
                int g, d;
                g = gen;
                d = (resp_delay > 0) ? resp_delay : int'($urandom_range(1, 5));
                repeat (d) @(posedge clk);
                #1;
                if (g == gen && !rst) begin
                    runner_done   = 1'b1;
                    last_done_cyc = cyc;
                    @(posedge clk);
                    #1 runner_done = 1'b0;
                end
            end
        end
    end

    task automatic run_layer(input int h, input int w, input int th, input int tw,
                             input int s, input int abort_n);
        int  ends0;
        bit  aborted, finished;
        build_layer(h, w, th, tw, s, abort_n);
        starts_seen = 0;
        first_tile  = 1'b1;
        ends0       = layer_ends;
        aborted     = 1'b0;
        finished    = 1'b0;
        @(posedge clk); #1;
        cfg_out_img_h = DIM_W'(h);  cfg_out_img_w = DIM_W'(w);
        cfg_tile_h    = DIM_W'(th); cfg_tile_w    = DIM_W'(tw);
        cfg_stride    = DIM_W'(s);
        start = 1'b1;
        start_cyc = cyc;
        for (int i = 0; i < 20000 && !finished; i++) begin
            @(posedge clk); #1;
            start = 1'b0;
            abort = 1'b0;
            if (abort_n > 0 && !aborted && starts_seen >= abort_n) begin
                abort   = 1'b1;
                aborted = 1'b1;
            end
            if (layer_ends != ends0) finished = 1'b1;
        end
        abort = 1'b0;
        if (!finished) begin
            fail_now("layer_timeout");
            exp_tiles.delete();
            exp_end.delete();
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},         busy, 0);
        check({tag, "_done"},         done, 0);
        check({tag, "_error"},        error, 0);
        check({tag, "_runner_start"}, runner_start, 0);
        check({tag, "_tile_in_row"},  $signed(tile_in_row), 0);
        check({tag, "_tile_in_h"},    tile_in_h, 0);
        check({tag, "_tile_out_col"}, tile_out_col, 0);
        check({tag, "_tile_out_w"},   tile_out_w, 0);
        check({tag, "_tile_count"},   tile_count, 0);
    endtask

    initial begin : stimulus
        bit seen;
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        cfg_out_img_h = '0; cfg_out_img_w = '0;
        cfg_tile_h = '0; cfg_tile_w = '0; cfg_stride = '0;
        repeat (3) @(posedge clk);
        #1 check_all_zero("reset");
        @(negedge clk) rst = 1'b0;
        repeat (2) @(posedge clk);

        // runner_done while idle must be ignored
        #1 runner_done = 1'b1;
        @(posedge clk); #1 runner_done = 1'b0;
        check("idle_runner_done_busy", busy, 0);

        resp_delay = 10;
        run_layer(8, 8, 4, 4, 1, 0);
        run_layer(8, 8, 4, 4, 2, 0);
        resp_delay = 0;
        run_layer(10, 10, 4, 4, 1, 0);
        run_layer(8, 8, 4, 4, 3, 0);       // bad stride
        run_layer(32, 32, 16, 16, 2, 0);   // 33-wide window, accepted
        run_layer(32, 32, 17, 17, 2, 0);   // 35-wide window, rejected
        run_layer(32, 32, 16, 17, 2, 0);   // width alone too large
        run_layer(0, 8, 4, 4, 1, 0);       // zero dimension
        run_layer(8, 8, 4, 4, 1, 2);       // abort during second tile

        // Reset in the middle of S_WAIT
        resp_delay = 10;
        exp_tiles.delete(); exp_end.delete();
        build_layer(8, 8, 4, 4, 1, 0);
        starts_seen = 0; first_tile = 1'b1;
        @(posedge clk); #1;
        cfg_out_img_h = 8; cfg_out_img_w = 8; cfg_tile_h = 4; cfg_tile_w = 4; cfg_stride = 1;
        start = 1'b1; start_cyc = cyc;
        @(posedge clk); #1 start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(posedge clk); #1;
            if (starts_seen > 0) seen = 1'b1;
        end
        if (!seen) fail_now("reset_test_no_issue");
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        gen++;
        #1 check_all_zero("midrst");
        exp_tiles.delete(); exp_end.delete();
        @(negedge clk) rst = 1'b0;
        repeat (12) @(posedge clk);
        check("post_rst_idle", busy, 0);
        resp_delay = 0;
        run_layer(8, 8, 4, 4, 1, 0);

        // Randomised layers
        for (int k = 0; k < 24; k++) begin
            int h, w, th, tw, s, ab;
            h  = $urandom_range(1, 12);
            w  = $urandom_range(1, 12);
            th = ($urandom_range(0, 9) == 0) ? 18 : int'($urandom_range(1, 6));
            tw = $urandom_range(1, 6);
            s  = $urandom_range(1, 3);
            ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
            run_layer(h, w, th, tw, s, ab);
        end

        repeat (5) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin : watchdog
        #5_000_000;
        $display("FAIL global_timeout at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/dws_layer_tile_scheduler.md
Name: dws_layer_tile_scheduler

Overview:
- Sequences one depthwise-separable layer by walking its output map in row-major tiles.
- For each tile it computes the padded input window and the edge-clipped output extent, then pulses start to the tile runner and waits for its done.
- Sits between the layer controller and the tile runner. The layer-level fields (image dims, channels, base addresses) go straight to the runner; only the per-tile fields come from this block.

Parameters:
- DIM_W, 16, width of dimension/coordinate fields.
- MAX_TILE_IN_H, 33, largest input window height the runner supports.
- MAX_TILE_IN_W, 33, largest input window width the runner supports.
- CNT_W, 16, width of the tile counter.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- start  in  1  begin layer; sampled only in S_IDLE.
- abort  in  1  stop after the current tile completes.
- busy  out  1  high when state != S_IDLE.
- done  out  1  one-cycle pulse at layer end, including abort or error.
- error  out  1  one-cycle pulse together with done when the configuration is rejected.
- cfg_out_img_h, cfg_out_img_w  in  DIM_W  output map size.
- cfg_tile_h, cfg_tile_w  in  DIM_W  nominal output tile size.
- cfg_stride  in  DIM_W  1 or 2.
- runner_start  out  1  one-cycle pulse per tile.
- runner_done  in  1  one-cycle pulse from the runner.
- tile_in_row, tile_in_col  out  DIM_W+1 signed  input window origin, pad 1.
- tile_in_h, tile_in_w  out  DIM_W  input window extent.
- tile_out_row, tile_out_col  out  DIM_W  output tile origin.
- tile_out_h, tile_out_w  out  DIM_W  clipped output extent.
- tile_count  out  CNT_W  tiles completed in the current layer.

Behaviour:
- Reset: state S_IDLE; all outputs 0.
- Tile outputs are registered and stable from S_SETUP until the next S_SETUP.
- States: S_IDLE, S_CHECK, S_SETUP, S_ISSUE, S_WAIT, S_ADVANCE, S_DONE.
- S_IDLE, start=1:
  - latch cfg;
  - clear row/col cursors and tile_count;
  - go to S_CHECK.
- S_CHECK rejects the configuration when any of these hold:
  - any cfg dimension is 0;
  - stride is not 1 or 2;
  - (cfg_tile_h-1)*stride+3 > MAX_TILE_IN_H, or the equivalent W check fails.
  - On reject, go to S_DONE with error armed; otherwise go to S_SETUP.
- S_SETUP:
  - out_h = min(cfg_tile_h, out_img_h - row); out_w likewise for columns.
  - in_row = row*stride - 1, computed signed; stride 2 is a left shift, no multiplier.
  - in_h = (out_h-1)*stride + 3; the W fields likewise.
  - Next state S_ISSUE.
- S_ISSUE: runner_start=1 for exactly this cycle; go to S_WAIT.
  - Latency: start to runner_start is 3 cycles (start edge, CHECK, SETUP, ISSUE).
- S_WAIT:
  - hold until runner_done=1, then tile_count+1 and go to S_ADVANCE;
  - runner_done outside S_WAIT is ignored.
- S_ADVANCE:
  - col += cfg_tile_w; if col >= out_img_w then col=0 and row += cfg_tile_h;
  - if row >= out_img_h, or abort was latched, go to S_DONE; otherwise go to S_SETUP.
  - runner_done to the next runner_start is 3 cycles.
- abort:
  - latched (sticky) in any non-IDLE state;
  - never cuts off a runner tile in flight;
  - abort in S_CHECK/S_SETUP before the first issue goes directly to S_DONE;
  - cleared on entry to S_IDLE.
- S_DONE: done=1 for one cycle (plus error if armed); go to S_IDLE.
- start while busy is ignored.
- Arithmetic:
  - cursor adds are done in DIM_W+1 bits so the wrap compare cannot overflow;
  - tile_count saturates at all-ones.
- rst mid-layer forces S_IDLE immediately with outputs zeroed; no done pulse.

Decomposition:
- Shared package dws_sched_pkg holds:
  - the state enum;
  - the PAD=1 and KERNEL=3 constants;
  - a function computing in_extent(out_ext, stride).
- One sub-module, dws_tile_geom, is natural: a combinational calculator from (row, col, cfg) to the six tile fields, registered by the parent in S_SETUP.

Test Plan:
- 8x8 out, tile 4x4, stride 1, runner_done 10 cycles after each start → 4 runner_starts. Tiles are (0,0), (0,4), (4,0), (4,4), each with tile_in_row/col at -1 or 3 and tile_in_h=6. done once; tile_count=4.
- 8x8 out, tile 4x4, stride 2 → tile0 in_row=-1, in_h=9. Tile (4,4) gives in_row=7, in_col=7. Four tiles total.
- 10x10 out, tile 4x4, stride 1 → 9 tiles. The last is out_row=8, out_h=2, in_h=4, out_w=2, in_w=4.
- Stride 3, or tile 16x16 with stride 2 (in 33 ok) vs tile 17x17 with stride 2 (in 35 > 33) → done+error with no runner_start for the rejected case; the accepted case issues normally.
- abort pulsed during S_WAIT of tile 1 → that tile's runner_done is still awaited. done follows, tile_count=2, and no third runner_start.
- rst asserted in S_WAIT → busy=0 and all outputs 0 the same cycle. A fresh start afterwards restarts at tile (0,0).
